// File: rtl/demux4_deserializer.sv
// Assembles four independent MSB-first WIDTH-bit words from the demux lanes and round-robins them onto one output port.
// Latency: final bit sampled at edge E -> lane pending after E -> out_valid after E+1 (output idle).
// Backpressure: one hold slot per lane; a lane completing while its slot is still full drops the word and sets sticky overflow.
module demux4_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic [1:0]       sel,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_ch,
  output logic [3:0]       overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Only the low WIDTH-1 bits of each shifter are kept: the top bit would be
  // shifted out on the completing bit and never reaches the hold register.
  logic [3:0][WIDTH-2:0] r_sh;
  logic [3:0][CW-1:0]    r_cnt;
  logic [3:0][WIDTH-1:0] r_hold;
  logic [3:0]            r_pend;
  logic [3:0]            r_ovf;
  logic                  r_out_valid;
  logic [WIDTH-1:0]      r_out_data;
  logic [1:0]            r_out_ch;
  logic [1:0]            r_last;

  logic [3:0]            w_y;
  logic                  w_bit;
  logic [3:0]            w_strobe;
  logic [3:0]            w_done;
  logic [3:0][WIDTH-1:0] w_word;
  logic                  w_load;
  logic                  w_found;
  logic [1:0]            w_pick;
  logic [3:0]            w_grant;

  assign w_y   = {y3, y2, y1, y0};
  assign w_bit = w_y[sel];

  // Per-lane strobe, completion detect and the word formed by the incoming bit.
  always_comb begin
    w_strobe = 4'b0000;
    w_done   = 4'b0000;
    w_word   = '0;
    for (int i = 0; i < 4; i++) begin
      w_strobe[i] = bit_valid && (sel == 2'(i));
      w_done[i]   = w_strobe[i] && (r_cnt[i] == CW'(WIDTH - 1));
      w_word[i]   = {r_sh[i], w_bit};
    end
  end

  // Output slot can take a new word when empty or being drained this cycle.
  assign w_load = !r_out_valid || out_ready;

  // Round-robin search over the registered pending flags, starting after the last grant.
  always_comb begin
    w_pick  = r_last + 2'd1;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && r_pend[r_last + 2'(k)]) begin
        w_pick  = r_last + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_grant = (w_load && w_found) ? (4'b0001 << w_pick) : 4'b0000;

  // Lane state: shifting, word completion into hold, pending and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
      r_pend <= 4'b0000;
      r_ovf  <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_strobe[i]) begin
          r_sh[i] <= w_word[i][WIDTH-2:0];
          if (w_done[i]) begin
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CW'(1);
          end
        end
        // A grant frees the slot in the same cycle, so a completing word may refill it.
        if (w_done[i] && (!r_pend[i] || w_grant[i])) begin
          r_hold[i] <= w_word[i];
          r_pend[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (w_done[i] && r_pend[i] && !w_grant[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Output register: loads the arbiter's pick, or empties when nothing is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= 2'd0;
      r_last      <= 2'd3;
    end else if (w_load) begin
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_hold[w_pick];
        r_out_ch    <= w_pick;
        r_last      <= w_pick;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_demux4_deserializer.sv
// Bench for demux4_deserializer: vector table for single-word and interleave
// traffic, hand-written sequences for backpressure, overflow and mid-word reset.
module tb_demux4_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bit_valid;
  logic [1:0]   sel;
  logic         y0, y1, y2, y3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_ch;
  logic [3:0]   overflow;

  int total = 0;
  int bad   = 0;
  int vcount;

  typedef struct {
    logic       rn;
    logic       bv;
    logic [1:0] s;
    logic [3:0] y;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ech;
    logic [3:0] eovf;
  } vec_t;

  vec_t vq[$];

  demux4_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_valid (bit_valid),
    .sel       (sel),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic bv, input logic [1:0] s,
                       input logic [3:0] yy, input logic rdy);
    rst_n     = rn;
    bit_valid = bv;
    sel       = s;
    {y3, y2, y1, y0} = yy;
    out_ready = rdy;
  endtask

  task automatic step(input logic rn, input logic bv, input logic [1:0] s,
                      input logic [3:0] yy, input logic rdy);
    drive(rn, bv, s, yy, rdy);
    @(posedge clk);
    #1;
  endtask

  // No strobe: sel and y wander randomly and must not disturb any lane.
  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, 2'($urandom), 4'($urandom), rdy);
  endtask

  // Eight MSB-first strobes on one lane; the other lanes carry the inverted bit.
  task automatic send_word(input logic [1:0] lane, input logic [7:0] w, input logic rdy);
    for (int b = 7; b >= 0; b--) begin
      logic [3:0] yy;
      yy = w[b] ? (4'b0001 << lane) : ~(4'b0001 << lane);
      step(1'b1, 1'b1, lane, yy, rdy);
      if (out_valid) vcount++;
    end
  endtask

  task automatic add(input logic rn, input logic bv, input logic [1:0] s, input logic [3:0] yy,
                     input logic rdy, input logic ev, input logic [7:0] ed,
                     input logic [1:0] ech, input logic [3:0] eo);
    vec_t v;
    v.rn = rn; v.bv = bv; v.s = s; v.y = yy; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ech = ech; v.eovf = eo;
    vq.push_back(v);
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [7:0] ed,
                         input logic [1:0] ech, input logic [3:0] eo);
    chk({nm, " valid"}, 32'(out_valid), 32'(ev));
    chk({nm, " ovf"}, 32'(overflow), 32'(eo));
    if (ev) begin
      chk({nm, " data"}, 32'(out_data), 32'(ed));
      chk({nm, " ch"}, 32'(out_ch), 32'(ech));
    end
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    // ---------------- reset ----------------
    drive(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst data", 32'(out_data), 32'd0);
    chk("rst ch", 32'(out_ch), 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("post-rst valid", 32'(out_valid), 32'd0);
    chk("post-rst data", 32'(out_data), 32'd0);
    chk("post-rst ovf", 32'(overflow), 32'd0);

    // ---------------- vector table ----------------
    // Single word 0xA5 on lane 2 with a non-strobe gap mid-word.
    for (int b = 7; b >= 0; b--) begin
      add(1'b1, 1'b1, 2'd2, a5[b] ? 4'b0100 : 4'b1011, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
      if (b == 4) add(1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    end
    add(1'b1, 1'b0, 2'd1, 4'b1111, 1'b1, 1'b1, 8'hA5, 2'd2, 4'b0000);
    add(1'b1, 1'b0, 2'd3, 4'b0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
    // Interleave: lane 0 gets ones, lane 1 gets zeros, alternating strobes.
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) add(1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
      else if (k < 15) add(1'b1, 1'b1, 2'd1, 4'b1101, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);
      else add(1'b1, 1'b1, 2'd1, 4'b1101, 1'b1, 1'b1, 8'hFF, 2'd0, 4'b0000);
    end
    add(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b1, 8'h00, 2'd1, 4'b0000);
    add(1'b1, 1'b0, 2'd0, 4'b1111, 1'b1, 1'b0, 8'h00, 2'd0, 4'b0000);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rn, vq[i].bv, vq[i].s, vq[i].y, vq[i].rdy);
      chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].ech, vq[i].eovf);
    end

    // ---------------- round robin under backpressure ----------------
    send_word(2'd0, 8'h10, 1'b0);
    idle(1'b0);
    chk_out("rr first", 1'b1, 8'h10, 2'd0, 4'b0000);
    send_word(2'd1, 8'h11, 1'b0);
    send_word(2'd2, 8'h12, 1'b0);
    send_word(2'd3, 8'h13, 1'b0);
    idle(1'b0);
    chk_out("rr stall", 1'b1, 8'h10, 2'd0, 4'b0000);
    idle(1'b1);
    chk_out("rr ch1", 1'b1, 8'h11, 2'd1, 4'b0000);
    idle(1'b1);
    chk_out("rr ch2", 1'b1, 8'h12, 2'd2, 4'b0000);
    idle(1'b1);
    chk_out("rr ch3", 1'b1, 8'h13, 2'd3, 4'b0000);
    idle(1'b1);
    chk_out("rr drain", 1'b0, 8'h00, 2'd0, 4'b0000);

    // ---------------- overflow on lane 3 ----------------
    send_word(2'd3, 8'h01, 1'b0);
    idle(1'b0);
    chk_out("ovf w1", 1'b1, 8'h01, 2'd3, 4'b0000);
    send_word(2'd3, 8'h02, 1'b0);
    chk_out("ovf w2", 1'b1, 8'h01, 2'd3, 4'b0000);
    send_word(2'd3, 8'h03, 1'b0);
    chk_out("ovf w3", 1'b1, 8'h01, 2'd3, 4'b1000);
    idle(1'b1);
    chk_out("ovf out2", 1'b1, 8'h02, 2'd3, 4'b1000);
    idle(1'b1);
    chk_out("ovf no3", 1'b0, 8'h00, 2'd0, 4'b1000);
    idle(1'b1);
    chk_out("ovf sticky", 1'b0, 8'h00, 2'd0, 4'b1000);

    // ---------------- reset mid-word ----------------
    send_word(2'd0, 8'h77, 1'b0);
    idle(1'b0);
    chk_out("mid pre", 1'b1, 8'h77, 2'd0, 4'b1000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
    drive(1'b0, 1'b0, 2'd1, 4'b0000, 1'b1);
    #2;
    chk("mid async valid", 32'(out_valid), 32'd0);
    chk("mid async ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 2'd1, 4'b0000, 1'b1);
    vcount = 0;
    send_word(2'd1, 8'h3C, 1'b1);
    chk("mid no partial", 32'(vcount), 32'd0);
    idle(1'b1);
    chk_out("mid word", 1'b1, 8'h3C, 2'd1, 4'b0000);
    idle(1'b1);
    chk_out("mid after", 1'b0, 8'h00, 2'd0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux4_deserializer.md
# demux4_deserializer

Downstream consumer of the 1:4 bit demultiplexer. It takes the demux's four lane outputs plus the select and a bit strobe, and assembles an independent MSB-first word on each lane. Completed words are buffered one per lane and drained through a round-robin arbiter onto a single valid/ready output port. It sits between the demux and any word-oriented sink, and flags per-lane overflow when a sink stalls too long.

## Interface
- WIDTH, 8, bits per assembled word (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; one clock, reset is asynchronous and active-low
- bit_valid  input  1  strobe: bit on lane `sel` is valid this cycle
- sel  input  2  lane index driven to the demux; picks which of y0..y3 is sampled
- y0, y1, y2, y3  input  1 each  demux lane outputs
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  sink accepts the word this cycle
- out_data  output  WIDTH  assembled word
- out_ch  output  2  lane the word came from
- overflow  output  4  sticky per-lane word-dropped flag

## Operation
- Per lane: WIDTH-bit shift register `sh[i]`, counter `cnt[i]` (0..WIDTH-1), hold register `hold[i]`, pending flag `pend[i]`.
- On a bit_valid cycle, only lane `sel` updates. Its bit is y[sel]; the other three y inputs are ignored.
  - Shift: `sh <= {sh[WIDTH-2:0], bit}`, MSB first.
  - `cnt` increments.
- Lanes keep independent state, so bits for different lanes may interleave freely.
- Word completion happens when `cnt == WIDTH-1` on a valid bit:
  - The completed word `{sh[WIDTH-2:0], bit}` is written to `hold`.
  - `pend` is set and `cnt` returns to 0.
- Completion while `pend` is already set and the lane is not granted this cycle:
  - The new word is dropped and `hold` is unchanged.
  - `overflow[i]` is set. It clears only on reset.
- Completion in the same cycle the lane is granted: the new word loads into `hold` and `pend` stays 1. No overflow.
- Output register load:
  - Loads when `!out_valid || out_ready`.
  - The arbiter picks the first lane with `pend` set, searching from `last+1` upward mod 4.
  - Loading copies `hold` into out_data and the lane into out_ch, sets out_valid, clears that lane's `pend`, and updates `last`.
  - If no lane is pending, out_valid goes low when out_ready is high.
- Arbitration uses the registered `pend`. A word completing in cycle N is not visible to the arbiter until cycle N+1.
- Arithmetic is unsigned and counters wrap only through the explicit reset to 0. There is no saturation path.

## Timing
- Reset (async assert, sync-safe deassert): all `sh`, `cnt`, `hold`, and `pend` are 0.
  - out_valid=0, out_data=0, out_ch=0, overflow=4'b0000.
  - `last`=3, so lane 0 has first priority.
- Latency with the output idle:
  - Final bit sampled at edge E.
  - `pend` is high after E.
  - out_valid is high after edge E+1.
- Handshake:
  - A transfer occurs on an edge with out_valid && out_ready.
  - out_data and out_ch are stable while out_valid && !out_ready.
  - Back-to-back transfers every cycle are supported.
- Reset asserted mid-word discards partial words, pending words, and the output word immediately. No spurious out_valid follows.
- bit_valid=0: shift state is unchanged regardless of sel or y.

## Test plan
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_ch=0, overflow=0; after release all stay 0 until stimulus.
- Single word: sel=2, bits 1,0,1,0,0,1,0,1 on y2 with out_ready=1 -> out_data=8'hA5, out_ch=2, out_valid high exactly 2 edges after the 8th bit, for one cycle.
- Interleave: alternate sel=0 (y0=1) and sel=1 (y1=0) for 16 strobes -> two words in order: 8'hFF on ch0, then 8'h00 on ch1.
- Round-robin under backpressure: out_ready=0, complete words 8'h10, 8'h11, 8'h12, 8'h13 on lanes 0..3 -> out holds 8'h10/ch0 steady; then out_ready=1 -> ch1, ch2, ch3 follow on consecutive cycles.
- Overflow: out_ready=0, complete three words on lane 3 (8'h01, 8'h02, 8'h03):
  - Required: overflow=4'b1000 after the third word.
  - Required: with out_ready=1, the output yields 8'h01 then 8'h02; 8'h03 never appears.
- Reset mid-word: 4 bits to lane 1, pulse rst_n low, then 8 bits 8'h3C on lane 1 -> single output 8'h3C/ch1, no partial word.
